ibex_multdiv_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit for RV32M/RV64M-style datapaths.

---
 rtl/ibex_pkg.sv | 26 ++
 rtl/ibex_multdiv_iter_mac.sv | 26 ++
 rtl/ibex_multdiv_iter.sv | 197 +++++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex types for the multiply/divide unit: operator encoding and
// the state encoding of the iterative multiply/divide FSM.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        MDI_IDLE = 3'd0,
        MDI_ABS  = 3'd1,
        MDI_MUL  = 3'd2,
        MDI_DIV  = 3'd3,
        MDI_FIX  = 3'd4,
        MDI_DONE = 3'd5
    } md_iter_state_e;

    // Multiply and divide operators differ only in the top opcode bit.
    function automatic logic md_is_mul(md_op_e op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter_mac.sv
// Combinational WIDTH x MUL_SLICE unsigned multiply, shifted to slice
// position idx_i and added into a 2*WIDTH accumulator.
// Ports: a_i (multiplicand), b_i (multiplier slice), idx_i (slice index),
//        acc_i (accumulator in), acc_o (accumulator out).
module ibex_multdiv_iter_mac #(
    parameter int WIDTH     = 32,
    parameter int MUL_SLICE = 16,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     a_i,
    input  logic [MUL_SLICE-1:0] b_i,
    input  logic [CW-1:0]        idx_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] prod;
    logic [31:0]        sh;

    always_comb begin
        prod  = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
        sh    = 32'(idx_i) * 32'(MUL_SLICE);
        acc_o = acc_i + (prod << sh);
    end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit: slice-wise multiply, radix-2 restoring
// divide, valid/ready handshake, kill and optional data-independent timing.
// Ports: clk_i, rst_ni, req_i/ready_o (accept), kill_i (flush),
//        operator_i, signed_mode_i, data_ind_timing_i, op_a_i, op_b_i,
//        result_o/valid_o/ready_i (result handshake).
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_SLICE = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             ready_o,
    input  logic             kill_i,
    input  md_op_e           operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic             data_ind_timing_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int N  = WIDTH / MUL_SLICE;
    localparam int CW = $clog2(WIDTH + 1);

    md_iter_state_e state_q, state_d;

    md_op_e             op_q;
    logic [1:0]         sm_q;
    logic               dit_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic [WIDTH-1:0]   res_q;

    logic               accept;
    logic               is_mul;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               b_zero;
    logic               early_abs;
    logic [CW-1:0]      mul_idx;
    logic [2*WIDTH-1:0] mac_out;
    logic [WIDTH+MUL_SLICE-1:0] opb_wide;
    logic [WIDTH-1:0]   opb_rest;
    logic               mul_last;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic               div_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_fix;

    assign accept = req_i & ~kill_i & (state_q == MDI_IDLE);
    assign is_mul = md_is_mul(op_q);

    // Magnitudes; opa_q/opb_q still hold the raw operands during ABS.
    assign sign_a    = sm_q[0] & opa_q[WIDTH-1];
    assign sign_b    = sm_q[1] & opb_q[WIDTH-1];
    assign abs_a     = sign_a ? -opa_q : opa_q;
    assign abs_b     = sign_b ? -opb_q : opb_q;
    assign b_zero    = (opb_q == '0);
    assign early_abs = ~dit_q & b_zero;

    // Multiply: opb_q shifts right one slice per step, so the low slice
    // is always the current one and the rest tells us if we can stop.
    assign mul_idx  = CW'(N) - cnt_q;
    assign opb_wide = {{MUL_SLICE{1'b0}}, opb_q} >> MUL_SLICE;
    assign opb_rest = opb_wide[WIDTH-1:0];
    assign mul_last = (cnt_q == CW'(1)) | (~dit_q & (opb_rest == '0));

    ibex_multdiv_iter_mac #(
        .WIDTH     (WIDTH),
        .MUL_SLICE (MUL_SLICE)
    ) u_mac (
        .a_i   (opa_q),
        .b_i   (opb_q[MUL_SLICE-1:0]),
        .idx_i (mul_idx),
        .acc_i (acc_q),
        .acc_o (mac_out)
    );

    // Divide: remainder in acc_q low half, numerator shifts out of
    // opa_q's MSB while quotient bits shift in at its LSB.
    assign rem_sh   = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, opb_q};
    assign rem_diff = rem_sh - {1'b0, opb_q};
    assign div_last = (cnt_q == CW'(1));

    // Sign fix-up; opb_q holds |b| unshifted for divides.
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = (neg_q & ~b_zero) ? -opa_q : opa_q;
    assign rem_fix  = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        res_fix = '0;
        case (op_q)
            MD_OP_MULL: res_fix = prod_fix[WIDTH-1:0];
            MD_OP_MULH: res_fix = prod_fix[2*WIDTH-1:WIDTH];
            MD_OP_DIV:  res_fix = quo_fix;
            MD_OP_REM:  res_fix = rem_fix;
            default:    res_fix = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MDI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDI_IDLE: if (accept) state_d = MDI_ABS;
            MDI_ABS: begin
                if (early_abs)   state_d = MDI_FIX;
                else if (is_mul) state_d = MDI_MUL;
                else             state_d = MDI_DIV;
            end
            MDI_MUL:  if (mul_last) state_d = MDI_FIX;
            MDI_DIV:  if (div_last) state_d = MDI_FIX;
            MDI_FIX:  state_d = MDI_DONE;
            MDI_DONE: if (ready_i) state_d = MDI_IDLE;
            default:  state_d = MDI_IDLE;
        endcase
        if (kill_i && state_q != MDI_IDLE) state_d = MDI_IDLE;
    end

    always_comb begin
        ready_o = (state_q == MDI_IDLE);
        valid_o = (state_q == MDI_DONE);
    end

    assign result_o = res_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= MD_OP_MULL;
            sm_q      <= '0;
            dit_q     <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            res_q     <= '0;
        end else begin
            case (state_q)
                MDI_IDLE: begin
                    if (accept) begin
                        op_q  <= operator_i;
                        sm_q  <= signed_mode_i;
                        dit_q <= data_ind_timing_i;
                        opa_q <= op_a_i;
                        opb_q <= op_b_i;
                    end
                end
                MDI_ABS: begin
                    // Divide-by-zero early-out preloads the final
                    // quotient (all ones) and remainder (|a|).
                    opa_q     <= (early_abs & ~is_mul) ? '1 : abs_a;
                    opb_q     <= abs_b;
                    acc_q     <= (early_abs & ~is_mul) ?
                                 {{WIDTH{1'b0}}, abs_a} : '0;
                    neg_q     <= sign_a ^ sign_b;
                    rem_neg_q <= sign_a;
                    cnt_q     <= is_mul ? CW'(N) : CW'(WIDTH);
                end
                MDI_MUL: begin
                    acc_q <= mac_out;
                    opb_q <= opb_rest;
                    cnt_q <= cnt_q - CW'(1);
                end
                MDI_DIV: begin
                    acc_q[WIDTH-1:0] <= rem_ge ? rem_diff[WIDTH-1:0]
                                               : rem_sh[WIDTH-1:0];
                    opa_q <= {opa_q[WIDTH-2:0], rem_ge};
                    cnt_q <= cnt_q - CW'(1);
                end
                MDI_FIX: res_q <= res_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed testbench for ibex_multdiv_iter (WIDTH=32, MUL_SLICE=16).
// Checks results, latency, backpressure, kill and reset behaviour.
module tb_ibex_multdiv_iter;
    import ibex_pkg::*;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_i = 1'b0;
    logic         ready_o;
    logic         kill_i = 1'b0;
    md_op_e       operator_i = MD_OP_MULL;
    logic [1:0]   signed_mode_i = 2'b00;
    logic         dit_i = 1'b0;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic [W-1:0] result_o;
    logic         valid_o;
    logic         ready_i = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    ibex_multdiv_iter #(
        .WIDTH     (W),
        .MUL_SLICE (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_i             (req_i),
        .ready_o           (ready_o),
        .kill_i            (kill_i),
        .operator_i        (operator_i),
        .signed_mode_i     (signed_mode_i),
        .data_ind_timing_i (dit_i),
        .op_a_i            (op_a_i),
        .op_b_i            (op_b_i),
        .result_o          (result_o),
        .valid_o           (valid_o),
        .ready_i           (ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input md_op_e op,
                          input logic [1:0] sm, input logic dit,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat,
                          input int hold);
        int cyc;
        @(negedge clk_i);
        operator_i = op;
        signed_mode_i = sm;
        dit_i = dit;
        op_a_i = a;
        op_b_i = b;
        req_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        op_a_i = ~a;
        op_b_i = ~b;
        signed_mode_i = ~sm;
        chk({tag, " busy"}, 64'(ready_o), 64'd0);
        cyc = 0;
        while (!valid_o && cyc < 100) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk({tag, " lat"}, 64'(cyc), 64'(lat));
        chk({tag, " res"}, 64'(result_o), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            chk({tag, " hold valid"}, 64'(valid_o), 64'd1);
            chk({tag, " hold res"}, 64'(result_o), 64'(exp));
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk({tag, " ready after"}, 64'(ready_o), 64'd1);
        chk({tag, " valid after"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        int seen;

        #1;
        chk("reset ready", 64'(ready_o), 64'd1);
        chk("reset valid", 64'(valid_o), 64'd0);
        chk("reset result", 64'(result_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Multiply
        run_op("mull", MD_OP_MULL, 2'b00, 1'b1,
               32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 4, 0);
        run_op("mull eo", MD_OP_MULL, 2'b00, 1'b0,
               32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 3, 0);
        run_op("mulh ss", MD_OP_MULH, 2'b11, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4, 0);
        run_op("mulhu", MD_OP_MULH, 2'b00, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 0);
        run_op("mulhsu", MD_OP_MULH, 2'b01, 1'b0,
               32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 3, 0);
        run_op("mull neg", MD_OP_MULL, 2'b11, 1'b0,
               32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 3, 0);
        run_op("mulh hi", MD_OP_MULH, 2'b00, 1'b0,
               32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 4, 0);
        run_op("mull b0", MD_OP_MULL, 2'b00, 1'b0,
               32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 2, 0);

        // Divide
        run_op("div ovf", MD_OP_DIV, 2'b11, 1'b0,
               32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        run_op("rem ovf", MD_OP_REM, 2'b11, 1'b0,
               32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
        run_op("div neg", MD_OP_DIV, 2'b11, 1'b0,
               32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 0);
        run_op("rem neg", MD_OP_REM, 2'b11, 1'b0,
               32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0);
        run_op("divu", MD_OP_DIV, 2'b00, 1'b0,
               32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34, 0);
        run_op("remu", MD_OP_REM, 2'b00, 1'b0,
               32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34, 0);
        run_op("div0 eo", MD_OP_DIV, 2'b11, 1'b0,
               32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 2, 0);
        run_op("rem0 eo", MD_OP_REM, 2'b11, 1'b0,
               32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 2, 0);
        run_op("div0 dit", MD_OP_DIV, 2'b11, 1'b1,
               32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 34, 0);
        run_op("rem0 dit", MD_OP_REM, 2'b11, 1'b1,
               32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 34, 0);

        // Backpressure: result held while ready_i is low
        run_op("bp divu", MD_OP_DIV, 2'b00, 1'b0,
               32'd100, 32'd7, 32'd14, 34, 5);

        // Kill at cycle 10 of a divide
        @(negedge clk_i);
        operator_i = MD_OP_DIV;
        signed_mode_i = 2'b00;
        op_a_i = 32'd1000;
        op_b_i = 32'd3;
        req_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        chk("kill ready", 64'(ready_o), 64'd1);
        chk("kill valid", 64'(valid_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        chk("kill no result", 64'(seen), 64'd0);
        run_op("post kill", MD_OP_MULL, 2'b00, 1'b0,
               32'd7, 32'd6, 32'd42, 3, 0);

        // req_i together with kill_i is dropped
        @(negedge clk_i);
        req_i = 1'b1;
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        kill_i = 1'b0;
        chk("req+kill idle", 64'(ready_o), 64'd1);
        repeat (5) @(posedge clk_i);
        #1;
        chk("req+kill no valid", 64'(valid_o), 64'd0);

        // Asynchronous reset mid-operation
        @(negedge clk_i);
        operator_i = MD_OP_DIV;
        op_a_i = 32'd50;
        op_b_i = 32'd5;
        req_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst mid ready", 64'(ready_o), 64'd1);
        chk("rst mid valid", 64'(valid_o), 64'd0);
        chk("rst mid result", 64'(result_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op("post rst", MD_OP_REM, 2'b00, 1'b0,
               32'd50, 32'd7, 32'd1, 34, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
